// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes, ALU opcodes, control-FSM and divider states.
// Used by the control FSM and by the regfile_alu execute stage.
package cpu_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned NREG       = 16;
  localparam int unsigned AW         = $clog2(NREG);
  localparam int unsigned DIV_CYCLES = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_MULT = 3'd2,
    ALU_NAND = 3'd3,
    ALU_DIV  = 3'd4,
    ALU_MOD  = 3'd5,
    ALU_LT   = 3'd6,
    ALU_LTE  = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StLw, StSw,
    StBlt1, StBlt2, StBge1, StBge2, StBeq1, StBeq2, StHalt
  } cpu_state_e;

  typedef enum logic {
    DivIdle,
    DivRun
  } div_state_e;

endpackage

// File: rtl/div16_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module div16_iter
  import cpu_pkg::*;
#(
  parameter int unsigned Width  = 16,
  parameter int unsigned Cycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(Cycles);

  div_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [Width:0]    trial;
  logic [Width-1:0]  diff, rem_next, quo_next;
  logic              ge;

  always_comb begin
    trial    = {rem_q, quo_q[Width-1]};
    ge       = trial >= {1'b0, dvs_q};
    // When ge holds the true difference fits in Width bits.
    diff     = trial[Width-1:0] - dvs_q;
    rem_next = ge ? diff : trial[Width-1:0];
    quo_next = {quo_q[Width-2:0], ge};
  end

  assign busy_o      = (state_q == DivRun);
  assign done_o      = (state_q == DivRun) && (cnt_q == CntW'(Cycles - 1));
  assign quotient_o  = quo_next;
  assign remainder_o = rem_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    unique case (state_q)
      DivIdle: begin
        if (start_i) begin
          state_d = DivRun;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dividend_i;
          dvs_d   = divisor_i;
        end
      end
      DivRun: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (done_o) begin
          state_d = DivIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end

endmodule

// File: rtl/regfile_alu.sv
// Execute stage: 16x16 register file, operand select, 8-op ALU with iterative DIV/MOD.
// Optional REGFILE_R0_ZERO_EN makes register 0 hard-wired to zero.
module regfile_alu
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          exec,
  input  logic [AW-1:0] reg_addr_a,
  input  logic [AW-1:0] reg_addr_b,
  input  logic [AW-1:0] reg_addr_c,
  input  logic          reg_we,
  input  logic [2:0]    alu_op,
  input  logic          im_en,
  input  logic [3:0]    imm,
  input  logic          ld_en,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] regA,
  output logic [DW-1:0] regB,
  output logic [DW-1:0] alu_status,
  output logic          busy
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] status_q, status_d;
  logic          div_mod_q, div_mod_d, div_we_q, div_we_d;
  logic [AW-1:0] div_addr_q, div_addr_d;

  logic [DW-1:0] opa, opb, result, quo, rem;
  logic          issue, is_div, div_start, div_busy, div_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign regA = (R0Zero && reg_addr_a == '0) ? '0 : rf_q[reg_addr_a];
  assign regB = (R0Zero && reg_addr_b == '0) ? '0 : rf_q[reg_addr_b];

  assign opa       = im_en ? DW'(imm) : regA;
  assign opb       = regB;
  assign is_div    = (alu_op == ALU_DIV) || (alu_op == ALU_MOD);
  assign issue     = exec && !div_busy;
  assign div_start = issue && is_div;
  assign busy       = div_busy;
  assign alu_status = status_q;

  always_comb begin
    result = '0;
    unique case (alu_op_e'(alu_op))
      ALU_ADD:  result = opb + opa;
      ALU_SUB:  result = opb - opa;
      ALU_MULT: result = opb * opa;
      ALU_NAND: result = ~(opb & opa);
      ALU_LT:   result = DW'(opb < opa);
      ALU_LTE:  result = DW'(opb <= opa);
      ALU_DIV, ALU_MOD: result = '0;
      default:  result = '0;
    endcase
  end

  div16_iter #(
    .Width  (DW),
    .Cycles (DIV_CYCLES)
  ) u_div (
    .clk_i       (clk),
    .rst_ni      (reset),
    .start_i     (div_start),
    .dividend_i  (opb),
    .divisor_i   (opa),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Divider completion and a new single-cycle issue are mutually exclusive (issue needs !busy).
  always_comb begin
    rf_d       = rf_q;
    status_d   = status_q;
    div_mod_d  = div_mod_q;
    div_we_d   = div_we_q;
    div_addr_d = div_addr_q;
    wr_en      = 1'b0;
    wr_addr    = reg_addr_c;
    wr_data    = result;
    if (div_done) begin
      wr_en    = div_we_q;
      wr_addr  = div_addr_q;
      wr_data  = div_mod_q ? rem : quo;
      status_d = wr_data;
    end else if (div_start) begin
      div_mod_d  = (alu_op == ALU_MOD);
      div_we_d   = reg_we;
      div_addr_d = reg_addr_c;
    end else if (issue) begin
      status_d = result;
      wr_en    = reg_we;
      wr_data  = ld_en ? ld_data : result;
    end
    if (wr_en && !(R0Zero && wr_addr == '0)) begin
      rf_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      status_q   <= '0;
      div_mod_q  <= 1'b0;
      div_we_q   <= 1'b0;
      div_addr_q <= '0;
    end else begin
      rf_q       <= rf_d;
      status_q   <= status_d;
      div_mod_q  <= div_mod_d;
      div_we_q   <= div_we_d;
      div_addr_q <= div_addr_d;
    end
  end

endmodule

// File: tb/tb_regfile_alu.sv
// Directed, table-driven bench for regfile_alu plus divider and reset-abort sequences.
// Honours REGFILE_R0_ZERO_EN for the register-0 expectation.
module tb_regfile_alu;
  import cpu_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          exec, reg_we, im_en, ld_en;
  logic [3:0]    reg_addr_a, reg_addr_b, reg_addr_c, imm;
  logic [2:0]    alu_op;
  logic [15:0]   ld_data, regA, regB, alu_status;
  logic          busy;

  int checks = 0;
  int errors = 0;

  regfile_alu dut (
    .clk        (clk),
    .reset      (reset),
    .exec       (exec),
    .reg_addr_a (reg_addr_a),
    .reg_addr_b (reg_addr_b),
    .reg_addr_c (reg_addr_c),
    .reg_we     (reg_we),
    .alu_op     (alu_op),
    .im_en      (im_en),
    .imm        (imm),
    .ld_en      (ld_en),
    .ld_data    (ld_data),
    .regA       (regA),
    .regB       (regB),
    .alu_status (alu_status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ex;
    logic [2:0]  op;
    logic [3:0]  a, b, c;
    logic        we, im;
    logic [3:0]  imm;
    logic        ld;
    logic [15:0] ldd;
    logic [15:0] st;
    logic [3:0]  chk;
    logic [15:0] rv;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [3:0] addr, input string name, input logic [15:0] exp);
    reg_addr_a = addr;
    #1;
    check(name, regA, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic we, input logic im,
                       input logic [3:0] iv);
    exec = 1'b1; alu_op = op; reg_addr_a = a; reg_addr_b = b; reg_addr_c = c;
    reg_we = we; im_en = im; imm = iv; ld_en = 1'b0; ld_data = '0;
  endtask

  // DIV/MOD of r4 by r<dvs> into r6; two exec pulses are issued while busy and must be ignored.
  task automatic do_div(input string name, input logic [2:0] op, input logic [3:0] dvs,
                        input logic [15:0] prev_st, input logic [15:0] prev_r6,
                        input logic [15:0] exp);
    drive(op, dvs, 4'd4, 4'd6, 1'b1, 1'b0, 4'd0);
    step();
    exec = 1'b0;
    check({name, "_busy_start"}, {15'd0, busy}, 16'd1);
    for (int i = 1; i < 16; i++) begin
      if (i == 3 || i == 9) drive(ALU_ADD, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 4'd9);
      step();
      exec = 1'b0;
    end
    check({name, "_busy_last"}, {15'd0, busy}, 16'd1);
    check({name, "_status_held"}, alu_status, prev_st);
    read_a(4'd6, {name, "_r6_held"}, prev_r6);
    step();
    check({name, "_busy_done"}, {15'd0, busy}, 16'd0);
    check({name, "_status"}, alu_status, exp);
    read_a(4'd6, {name, "_r6"}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r0_exp;
`ifdef REGFILE_R0_ZERO_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'h0009;
`endif
    //            ex  op        a  b  c  we im imm ld ldd       st        chk rv
    vecs.push_back('{1, ALU_ADD,  0, 0, 1, 1, 1, 5, 0, 16'h0,   16'h0005, 1, 16'h0005});
    vecs.push_back('{1, ALU_ADD,  0, 0, 2, 1, 1, 0, 1, 16'h3,   16'h0000, 2, 16'h0003});
    vecs.push_back('{1, ALU_ADD,  0, 0, 8, 1, 1, 0, 1, 16'h7,   16'h0000, 8, 16'h0007});
    vecs.push_back('{1, ALU_SUB,  2, 1, 3, 1, 0, 0, 0, 16'h0,   16'h0002, 3, 16'h0002});
    vecs.push_back('{1, ALU_SUB,  1, 2, 7, 1, 0, 0, 0, 16'h0,   16'hFFFE, 7, 16'hFFFE});
    vecs.push_back('{1, ALU_LT,   1, 2, 1, 0, 0, 0, 0, 16'h0,   16'h0001, 1, 16'h0005});
    vecs.push_back('{1, ALU_LTE,  2, 2, 2, 0, 0, 0, 0, 16'h0,   16'h0001, 2, 16'h0003});
    vecs.push_back('{1, ALU_LT,   0, 8, 8, 0, 1, 3, 0, 16'h0,   16'h0000, 8, 16'h0007});
    vecs.push_back('{1, ALU_MULT, 7, 1, 9, 1, 0, 0, 0, 16'h0,   16'hFFF6, 9, 16'hFFF6});
    vecs.push_back('{1, ALU_NAND, 1, 2, 10, 1, 0, 0, 0, 16'h0,  16'hFFFE, 10, 16'hFFFE});
    vecs.push_back('{1, ALU_ADD,  7, 9, 11, 1, 0, 0, 0, 16'h0,  16'hFFF4, 11, 16'hFFF4});
    vecs.push_back('{0, ALU_ADD,  0, 0, 12, 1, 1, 1, 0, 16'h0,  16'hFFF4, 12, 16'h0000});
    vecs.push_back('{1, ALU_ADD,  0, 0, 4, 1, 1, 0, 1, 16'd100, 16'h0000, 4, 16'd100});
    vecs.push_back('{1, ALU_ADD,  0, 0, 5, 1, 1, 0, 1, 16'd7,   16'h0000, 5, 16'd7});
    vecs.push_back('{1, ALU_LTE,  0, 5, 5, 0, 1, 7, 0, 16'h0,   16'h0001, 5, 16'd7});
    vecs.push_back('{1, ALU_ADD,  0, 0, 0, 1, 1, 9, 0, 16'h0,   16'h0009, 0, r0_exp});

    reset = 1'b0; exec = 1'b0; reg_we = 1'b0; im_en = 1'b0; ld_en = 1'b0;
    reg_addr_a = '0; reg_addr_b = '0; reg_addr_c = '0; imm = '0; alu_op = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", alu_status, 16'h0);
    check("rst_busy", {15'd0, busy}, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    read_a(4'd1, "rst_r1", 16'h0);

    foreach (vecs[i]) begin
      exec = vecs[i].ex; alu_op = vecs[i].op; reg_addr_a = vecs[i].a; reg_addr_b = vecs[i].b;
      reg_addr_c = vecs[i].c; reg_we = vecs[i].we; im_en = vecs[i].im; imm = vecs[i].imm;
      ld_en = vecs[i].ld; ld_data = vecs[i].ldd;
      step();
      exec = 1'b0; ld_en = 1'b0;
      check($sformatf("vec%0d_status", i), alu_status, vecs[i].st);
      read_a(vecs[i].chk, $sformatf("vec%0d_reg", i), vecs[i].rv);
    end

    reg_addr_b = 4'd4;
    #1;
    check("regB_r4", regB, 16'd100);

    do_div("div",   ALU_DIV, 4'd5,  16'h0009, 16'h0000, 16'd14);
    do_div("mod",   ALU_MOD, 4'd5,  16'd14,   16'd14,   16'd2);
    do_div("div0",  ALU_DIV, 4'd13, 16'd2,    16'd2,    16'hFFFF);
    do_div("mod0",  ALU_MOD, 4'd13, 16'hFFFF, 16'hFFFF, 16'd100);

    // Reset in the middle of a division aborts it without write-back.
    drive(ALU_DIV, 4'd5, 4'd4, 4'd14, 1'b1, 1'b0, 4'd0);
    step();
    exec = 1'b0;
    repeat (8) step();
    reset = 1'b0;
    #1;
    check("abort_busy", {15'd0, busy}, 16'h0);
    check("abort_status", alu_status, 16'h0);
    for (int r = 0; r < 16; r++) read_a(4'(r), $sformatf("abort_r%0d", r), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) step();
    check("abort_busy_after", {15'd0, busy}, 16'h0);
    read_a(4'd14, "abort_r14_after", 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_alu.md
Name: regfile_alu

Overview:
- Execute stage directly downstream of the control FSM. Consumes its register addresses, write enable, ALU opcode, immediate enable and load data.
- Contains a 16x16 register file, operand/immediate select, and an 8-op ALU. DIV/MOD use an iterative 16-cycle divider.
- Returns regA/regB to the FSM for SW/LW addressing, and a registered alu_status for branch resolution.

Parameters:
- DW, 16, datapath width.
- NREG, 16, number of architectural registers; address width is log2(NREG).
- DIV_CYCLES, 16, iterations per DIV/MOD; must equal DW.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exec  in  1  one-cycle issue strobe for the current operation
- reg_addr_a  in  4  read port A address
- reg_addr_b  in  4  read port B address
- reg_addr_c  in  4  write address
- reg_we  in  1  write result to reg_addr_c on completion
- alu_op  in  3  0 ADD, 1 SUB, 2 MULT, 3 NAND, 4 DIV, 5 MOD, 6 LT, 7 LTE
- im_en  in  1  operand A replaced by zero-extended imm
- imm  in  4  immediate field
- ld_en  in  1  write ld_data instead of ALU result (LW)
- ld_data  in  16  load data from SRAM
- regA  out  16  combinational read of reg_addr_a
- regB  out  16  combinational read of reg_addr_b
- alu_status  out  16  registered result of last completed ALU operation
- busy  out  1  divider in progress; upstream must hold issue

Behaviour:
- Reset (async, reset==0): all registers 0, alu_status 0, busy 0, divider counter 0. Reset mid-division aborts it with no write-back.
- Reads are combinational and have no write bypass: a same-cycle read of a register being written returns the old value.
- Operands:
  - opA = im_en ? {12'd0, imm} : regA; opB = regB.
  - result = opB op opA, unsigned.
  - ADD/SUB wrap mod 2^16. MULT keeps the low 16 bits. NAND is bitwise.
  - LT = (opB < opA) ? 1 : 0; LTE = (opB <= opA) ? 1 : 0.
- Single-cycle ops (alu_op != 4, 5): on a rising edge with exec=1 and busy=0:
  - alu_status <= result.
  - If reg_we, reg[reg_addr_c] <= (ld_en ? ld_data : result).
  - Latency is 1 cycle; alu_status is valid the cycle after issue, which is when the FSM's BLT2/BGE2/BEQ2 sample it.
- ld_en: valid only with exec and reg_we; it does not suppress the alu_status update.
- DIV/MOD (alu_op 4, 5) with exec=1, busy=0:
  - Latch opB (dividend), opA (divisor), op, reg_addr_c and reg_we; busy <= 1.
  - Restoring division, one quotient bit per cycle for DIV_CYCLES cycles.
  - On the final iteration edge: busy <= 0, alu_status <= quotient (DIV) or remainder (MOD), and the latched write is performed. Issue-to-write latency is 17 edges.
  - Divisor 0: quotient 0xFFFF, remainder = dividend, still full latency.
- exec while busy=1: ignored entirely (no write, no status change).
- exec with exec=0: no state change. Register writes happen only via exec.
- Divider states: IDLE -> RUN (counter 0..DIV_CYCLES-1) -> IDLE, with write-back on the RUN->IDLE transition.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined: register 0 reads as 0 on both ports and writes to address 0 are discarded, including divider write-back.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package cpu_pkg: DW, register address width, alu_op encodings (ALU_ADD..ALU_LTE), and the FSM state encodings so both the FSM and this block use one definition.
- One sub-module: div16_iter. Start/busy/done handshake; outputs quotient, remainder and done pulse; owns the counter and the divide-by-zero rule.

Test Plan:
- Reset, then exec ADDI b=0, imm=5, c=1, im_en=1, reg_we=1 -> next cycle regA(addr 1)=0x0005, alu_status=0x0005.
- Load r2=0x0003 via ld_en, then SUB a=2, b=1, c=3 -> r3=0x0002. Then SUB a=1, b=2 -> 0xFFFE (wrap).
- LT a=1(5), b=2(3), reg_we=0 -> alu_status=0x0001, no register changed. LTE with equal operands -> 0x0001. LT with 7 vs 3 -> 0x0000.
- DIV r4=100 by r5=7 -> busy high for 16 cycles, exec pulses during busy ignored, then r6=14. MOD -> r6=2. Divisor 0 -> 0xFFFF (DIV) / 100 (MOD).
- Assert reset at divider cycle 8 -> busy=0 immediately, all registers 0, destination not written.
- With REGFILE_R0_ZERO_EN: ADDI c=0, imm=9 -> regA(addr 0) stays 0x0000 and alu_status=0x0009. Without the macro: reads 0x0009.
